// File: rtl/control_fsm_multicycle.sv
// Main control FSM of the multicycle processor: sequences fetch/decode/execute/memory/writeback
// with parameterised instruction- and data-memory wait states.
//
// state  | meaning
// FETCH  | read instruction at PC; IR load and PC+4 on the final wait cycle
// DECODE | read registers, PC+4 on ALU; dispatch on op
// MEMADR | compute load/store address
// MEMRD  | data memory read, waits DMEM_WAIT cycles
// MEMWB  | write loaded data to register file
// MEMWR  | data memory write, strobe on the final wait cycle
// EXECR  | ALU op, register operand
// EXECI  | ALU op, immediate operand
// ALUWB  | write ALU result to register file
// BRANCH | load branch target into PC
module control_fsm_multicycle #(
    parameter int IMEM_WAIT = 0,
    parameter int DMEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] op,
    input  logic       funct5,
    input  logic       funct0,
    output logic       irwrite,
    output logic       nextpc,
    output logic       adrsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       aluop,
    output logic       regw,
    output logic       memw,
    output logic       branch,
    output logic [1:0] immsrc,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [3:0] IMEM_LIM = 4'(IMEM_WAIT);
    localparam logic [3:0] DMEM_LIM = 4'(DMEM_WAIT);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_wcnt;
    logic [3:0] w_limit;
    logic       w_counted;
    logic       w_final;

    logic       w_irwrite;
    logic       w_nextpc;
    logic       w_regw;
    logic       w_memw;
    logic       w_branch;
    logic       w_illegal;
    logic       w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_wcnt  <= 4'd0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= (w_counted && !w_final) ? r_wcnt + 4'd1 : 4'd0;
        end
    end

    // Only FETCH, MEMRD and MEMWR stretch; every other state is its own final cycle.
    always_comb begin
        w_counted = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
        w_limit   = (r_state == S_FETCH) ? IMEM_LIM : DMEM_LIM;
        w_final   = !w_counted || (r_wcnt == w_limit);
    end

    always_comb begin
        w_next    = S_FETCH;
        adrsrc    = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        resultsrc = 2'b00;
        aluop     = 1'b0;
        immsrc    = op;
        w_irwrite = 1'b0;
        w_nextpc  = 1'b0;
        w_regw    = 1'b0;
        w_memw    = 1'b0;
        w_branch  = 1'b0;
        w_illegal = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_FETCH: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                w_irwrite = w_final;
                w_nextpc  = w_final;
                w_next    = w_final ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                case (op)
                    2'b00:   w_next = funct5 ? S_EXECI : S_EXECR;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                        w_done    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrcb = 2'b01;
                w_next  = funct0 ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adrsrc = 1'b1;
                w_next = w_final ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                w_regw    = 1'b1;
                w_done    = 1'b1;
            end
            S_MEMWR: begin
                adrsrc = 1'b1;
                w_memw = w_final;
                w_done = w_final;
                w_next = w_final ? S_FETCH : S_MEMWR;
            end
            S_EXECR: begin
                aluop  = 1'b1;
                w_next = S_ALUWB;
            end
            S_EXECI: begin
                alusrcb = 2'b01;
                aluop   = 1'b1;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_regw = 1'b1;
                w_done = 1'b1;
            end
            S_BRANCH: begin
                alusrcb   = 2'b01;
                resultsrc = 2'b10;
                w_branch  = 1'b1;
                w_done    = 1'b1;
            end
            default: begin
                immsrc = 2'b00;
            end
        endcase
    end

    // Strobes are masked during reset so an aborted instruction has no side effects.
    assign irwrite    = w_irwrite & ~rst;
    assign nextpc     = w_nextpc  & ~rst;
    assign regw       = w_regw    & ~rst;
    assign memw       = w_memw    & ~rst;
    assign branch     = w_branch  & ~rst;
    assign illegal    = w_illegal & ~rst;
    assign instr_done = w_done    & ~rst;
    assign state      = r_state;

endmodule

// File: tb/tb_control_fsm_multicycle.sv
// Bench for control_fsm_multicycle: three instances with different wait settings, an
// instruction-level reference model, a latency table and hand-written corner sequences.
module tb_control_fsm_multicycle;

    localparam int B_IRW  = 19;
    localparam int B_NPC  = 18;
    localparam int B_ALUOP = 11;
    localparam int B_REGW = 10;
    localparam int B_MEMW = 9;
    localparam int B_BR   = 8;
    localparam int B_ILL  = 5;
    localparam int B_DONE = 4;
    localparam logic [19:0] STROBES = 20'hC0730;

    typedef struct {
        int s;
        bit fin;
    } step_t;

    typedef struct {
        int         g;
        logic [1:0] op;
        logic       f5;
        logic       f0;
        int         lat;
        int         nr;
        int         nm;
        int         nb;
        int         ni;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [1:0]  op;
    logic        funct5;
    logic        funct0;
    logic [19:0] obs [3];
    logic [19:0] tr [16];

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp_v);
        end
    endtask

    // Expected full output vector for one cycle of a given state, straight from the output table.
    function automatic logic [19:0] expv(input int s, input bit fin, input logic [1:0] o);
        logic [19:0] v;
        v = '0;
        v[3:0] = 4'(s);
        v[7:6] = o;
        case (s)
            0: begin v[16] = 1'b1; v[15:14] = 2'b10; v[13:12] = 2'b10; v[B_IRW] = fin; v[B_NPC] = fin; end
            1: begin
                v[16] = 1'b1; v[15:14] = 2'b10; v[13:12] = 2'b10;
                if (o == 2'b11) begin v[B_ILL] = 1'b1; v[B_DONE] = 1'b1; end
            end
            2: v[15:14] = 2'b01;
            3: v[17] = 1'b1;
            4: begin v[13:12] = 2'b01; v[B_REGW] = 1'b1; v[B_DONE] = 1'b1; end
            5: begin v[17] = 1'b1; v[B_MEMW] = fin; v[B_DONE] = fin; end
            6: v[B_ALUOP] = 1'b1;
            7: begin v[15:14] = 2'b01; v[B_ALUOP] = 1'b1; end
            8: begin v[B_REGW] = 1'b1; v[B_DONE] = 1'b1; end
            9: begin v[15:14] = 2'b01; v[13:12] = 2'b10; v[B_BR] = 1'b1; v[B_DONE] = 1'b1; end
            default: v = '0;
        endcase
        return v;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int IW = (g == 2) ? 3 : 0;
        localparam int DW = (g == 1) ? 2 : 0;
        logic       irwrite, nextpc, adrsrc, alusrca, aluop, regw, memw, branch, illegal, instr_done;
        logic [1:0] alusrcb, resultsrc, immsrc;
        logic [3:0] state;
        step_t      q[$];

        control_fsm_multicycle #(.IMEM_WAIT(IW), .DMEM_WAIT(DW)) u_dut (
            .clk(clk), .rst(rst), .op(op), .funct5(funct5), .funct0(funct0),
            .irwrite(irwrite), .nextpc(nextpc), .adrsrc(adrsrc), .alusrca(alusrca),
            .alusrcb(alusrcb), .resultsrc(resultsrc), .aluop(aluop), .regw(regw),
            .memw(memw), .branch(branch), .immsrc(immsrc), .illegal(illegal),
            .instr_done(instr_done), .state(state)
        );

        assign obs[g] = {irwrite, nextpc, adrsrc, alusrca, alusrcb, resultsrc, aluop, regw,
                         memw, branch, immsrc, illegal, instr_done, state};

        // Instruction-level model: a queue of upcoming cycles, expanded when the
        // instruction class becomes known at DECODE and the direction at MEMADR.
        always @(negedge clk) begin
            step_t e;
            if (rst) begin
                q.delete();
                check($sformatf("rst_strobes_g%0d", g), 32'(obs[g] & STROBES), 32'd0);
            end else begin
                if (q.size() == 0) begin
                    for (int i = 0; i < IW; i++) q.push_back('{0, 1'b0});
                    q.push_back('{0, 1'b1});
                    q.push_back('{1, 1'b0});
                end
                e = q.pop_front();
                if (e.s == 1) begin
                    case (op)
                        2'b00: begin q.push_back('{funct5 ? 7 : 6, 1'b0}); q.push_back('{8, 1'b0}); end
                        2'b01: q.push_back('{2, 1'b0});
                        2'b10: q.push_back('{9, 1'b0});
                        default: ;
                    endcase
                end else if (e.s == 2) begin
                    if (funct0) begin
                        for (int i = 0; i <= DW; i++) q.push_back('{3, 1'b0});
                        q.push_back('{4, 1'b0});
                    end else begin
                        for (int i = 0; i < DW; i++) q.push_back('{5, 1'b0});
                        q.push_back('{5, 1'b1});
                    end
                end
                check($sformatf("model_g%0d", g), 32'(obs[g]), 32'(expv(e.s, e.fin, op)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic trace(input int g, input int start, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tr[start + i] = obs[g];
            tick();
        end
    endtask

    // Bit i of each mask is the expected strobe value in traced cycle i.
    task automatic chk_trace(input string nm, input int n, input logic [63:0] states,
                             input logic [15:0] e_irw, input logic [15:0] e_regw,
                             input logic [15:0] e_memw, input logic [15:0] e_br,
                             input logic [15:0] e_ill, input logic [15:0] e_done,
                             input logic [15:0] e_aluop);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_state[%0d]", nm, i), 32'(tr[i][3:0]), 32'(states[4*i +: 4]));
            check($sformatf("%s_irwrite[%0d]", nm, i), 32'(tr[i][B_IRW]), 32'(e_irw[i]));
            check($sformatf("%s_nextpc[%0d]", nm, i), 32'(tr[i][B_NPC]), 32'(e_irw[i]));
            check($sformatf("%s_regw[%0d]", nm, i), 32'(tr[i][B_REGW]), 32'(e_regw[i]));
            check($sformatf("%s_memw[%0d]", nm, i), 32'(tr[i][B_MEMW]), 32'(e_memw[i]));
            check($sformatf("%s_branch[%0d]", nm, i), 32'(tr[i][B_BR]), 32'(e_br[i]));
            check($sformatf("%s_illegal[%0d]", nm, i), 32'(tr[i][B_ILL]), 32'(e_ill[i]));
            check($sformatf("%s_done[%0d]", nm, i), 32'(tr[i][B_DONE]), 32'(e_done[i]));
            check($sformatf("%s_aluop[%0d]", nm, i), 32'(tr[i][B_ALUOP]), 32'(e_aluop[i]));
        end
    endtask

    initial begin
        vec_t        vec [14];
        logic [19:0] v;
        int          cyc, nr, nm, nb, ni;
        bit          got;

        //              g  op     f5    f0    lat nr nm nb ni
        vec[0]  = '{0, 2'b00, 1'b0, 1'b0, 4, 1, 0, 0, 0};
        vec[1]  = '{0, 2'b00, 1'b1, 1'b0, 4, 1, 0, 0, 0};
        vec[2]  = '{0, 2'b01, 1'b0, 1'b1, 5, 1, 0, 0, 0};
        vec[3]  = '{0, 2'b01, 1'b0, 1'b0, 4, 0, 1, 0, 0};
        vec[4]  = '{0, 2'b10, 1'b0, 1'b0, 3, 0, 0, 1, 0};
        vec[5]  = '{0, 2'b11, 1'b0, 1'b0, 2, 0, 0, 0, 1};
        vec[6]  = '{1, 2'b01, 1'b1, 1'b1, 7, 1, 0, 0, 0};
        vec[7]  = '{1, 2'b01, 1'b1, 1'b0, 6, 0, 1, 0, 0};
        vec[8]  = '{1, 2'b10, 1'b0, 1'b1, 3, 0, 0, 1, 0};
        vec[9]  = '{1, 2'b00, 1'b1, 1'b1, 4, 1, 0, 0, 0};
        vec[10] = '{2, 2'b00, 1'b0, 1'b0, 7, 1, 0, 0, 0};
        vec[11] = '{2, 2'b10, 1'b0, 1'b0, 6, 0, 0, 1, 0};
        vec[12] = '{2, 2'b11, 1'b1, 1'b1, 5, 0, 0, 0, 1};
        vec[13] = '{2, 2'b01, 1'b0, 1'b1, 8, 1, 0, 0, 0};

        rst = 1'b1; op = 2'b00; funct5 = 1'b0; funct0 = 1'b0;

        // Reset and first fetch cycle, zero waits
        do_reset();
        @(negedge clk);
        check("reset_state", 32'(obs[0][3:0]), 32'd0);
        check("reset_irwrite", 32'(obs[0][B_IRW]), 32'd1);
        check("reset_nextpc", 32'(obs[0][B_NPC]), 32'd1);
        check("reset_alusrcb", 32'(obs[0][15:14]), 32'd2);
        check("reset_alusrca", 32'(obs[0][16]), 32'd1);
        check("reset_other_strobes", 32'(obs[0] & 20'h00730), 32'd0);
        tick();

        // Register then immediate data-proc, zero waits
        do_reset();
        op = 2'b00; funct5 = 1'b0;
        trace(0, 0, 4);
        funct5 = 1'b1;
        trace(0, 4, 4);
        chk_trace("dp", 8, 64'h87108610, 16'h11, 16'h88, 16'h0, 16'h0, 16'h0, 16'h88, 16'h44);

        // Load then store, DMEM_WAIT = 2
        do_reset();
        op = 2'b01; funct0 = 1'b1;
        trace(1, 0, 7);
        chk_trace("load", 7, 64'h4333210, 16'h01, 16'h40, 16'h0, 16'h0, 16'h0, 16'h40, 16'h0);
        funct0 = 1'b0;
        trace(1, 0, 6);
        chk_trace("store", 6, 64'h555210, 16'h01, 16'h0, 16'h20, 16'h0, 16'h0, 16'h20, 16'h0);

        // Branch, IMEM_WAIT = 3
        do_reset();
        op = 2'b10;
        trace(2, 0, 6);
        chk_trace("branch", 6, 64'h910000, 16'h08, 16'h0, 16'h0, 16'h20, 16'h0, 16'h20, 16'h0);

        // Illegal opcode, zero waits
        do_reset();
        op = 2'b11;
        trace(0, 0, 3);
        chk_trace("illegal", 3, 64'h010, 16'h05, 16'h0, 16'h0, 16'h0, 16'h02, 16'h02, 16'h0);

        // Reset on the first MEMWR wait cycle aborts the store, then a clean store follows
        do_reset();
        op = 2'b01; funct0 = 1'b0;
        trace(1, 0, 3);
        chk_trace("abort_pre", 3, 64'h210, 16'h01, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", 32'(obs[1][3:0]), 32'd5);
        check("abort_memw", 32'(obs[1][B_MEMW]), 32'd0);
        check("abort_done", 32'(obs[1][B_DONE]), 32'd0);
        tick();
        rst = 1'b0;
        trace(1, 0, 6);
        chk_trace("abort_post", 6, 64'h555210, 16'h01, 16'h0, 16'h20, 16'h0, 16'h0, 16'h20, 16'h0);

        // Latency and strobe-count table
        for (int t = 0; t < 14; t++) begin
            do_reset();
            op = vec[t].op; funct5 = vec[t].f5; funct0 = vec[t].f0;
            cyc = 0; nr = 0; nm = 0; nb = 0; ni = 0; got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                v = obs[vec[t].g];
                cyc++;
                nr += int'(v[B_REGW]);
                nm += int'(v[B_MEMW]);
                nb += int'(v[B_BR]);
                ni += int'(v[B_ILL]);
                if (v[B_DONE]) got = 1'b1;
                tick();
            end
            check($sformatf("vec%0d_done_seen", t), 32'(got), 32'd1);
            check($sformatf("vec%0d_latency", t), 32'(cyc), 32'(vec[t].lat));
            check($sformatf("vec%0d_regw", t), 32'(nr), 32'(vec[t].nr));
            check($sformatf("vec%0d_memw", t), 32'(nm), 32'(vec[t].nm));
            check($sformatf("vec%0d_branch", t), 32'(nb), 32'(vec[t].nb));
            check($sformatf("vec%0d_illegal", t), 32'(ni), 32'(vec[t].ni));
        end

        // Random traffic; the model processes above check every instance each cycle
        for (int k = 0; k < 1500; k++) begin
            op     = 2'($urandom_range(0, 3));
            funct5 = 1'($urandom_range(0, 1));
            funct0 = 1'($urandom_range(0, 1));
            rst    = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/control_fsm_multicycle.md
Name: control_fsm_multicycle

Overview:
- Main control FSM for the multicycle processor. It replaces the single-cycle combinational main decoder.
- Sequences fetch, decode, execute, memory and writeback over several clocks.
- Supports parametrised instruction-memory and data-memory wait states, an illegal-opcode flag and a per-instruction retire pulse.
- Sits in the controller between the instruction register fields and the shared datapath/memory muxes. The ALU decoder consumes its aluop.

Parameters:
- IMEM_WAIT, 0, extra wait cycles per instruction fetch (0..15).
- DMEM_WAIT, 0, extra wait cycles per data read or write (0..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- op  in  2  instruction class: 00 data-proc, 01 memory, 10 branch, 11 illegal.
- funct5  in  1  immediate operand select for data-proc (1 = immediate).
- funct0  in  1  load/store select for memory class (1 = load).
- irwrite  out  1  instruction register load strobe.
- nextpc  out  1  PC update strobe (PC+4).
- adrsrc  out  1  memory address mux: 0 = PC, 1 = ALU result register.
- alusrca  out  1  ALU A mux: 0 = register, 1 = PC.
- alusrcb  out  2  ALU B mux: 00 = register, 01 = extended immediate, 10 = constant 4.
- resultsrc  out  2  result mux: 00 = ALU out register, 01 = data register, 10 = ALU result.
- aluop  out  1  1 = ALU decoder uses funct; 0 = add.
- regw  out  1  register file write strobe.
- memw  out  1  data memory write strobe.
- branch  out  1  branch PC-load strobe.
- immsrc  out  2  extension type: 00 data-proc, 01 memory, 10 branch; combinational from op.
- illegal  out  1  one-cycle pulse on decode of op = 11.
- instr_done  out  1  one-cycle pulse on the last cycle of every instruction.
- state  out  4  current state code (debug).

Behaviour:
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Codes 10–15 are unreachable; if entered, next state is FETCH with all outputs 0.
- Reset:
  - While rst = 1 at a clock edge: state <- FETCH, wait counter <- 0.
  - All strobes (irwrite, nextpc, regw, memw, branch, illegal, instr_done) are forced 0 combinationally while rst = 1.
  - Reset mid-instruction aborts it; no strobe fires in the cycle rst is high.
- Wait counter:
  - 4-bit, used only in FETCH (limit IMEM_WAIT) and in MEMRD/MEMWR (limit DMEM_WAIT).
  - Increments each cycle in the state until it equals the limit. That cycle is the final cycle: the counter clears and the transition is taken.
  - With limit 0, every state is exactly 1 cycle.
- Outputs are Moore-decoded from state. Any output not listed for a state is 0.
  - FETCH: adrsrc 0, alusrca 1, alusrcb 10, resultsrc 10, aluop 0. irwrite and nextpc are 1 only on the final cycle.
  - DECODE: alusrca 1, alusrcb 10, resultsrc 10.
  - MEMADR: alusrca 0, alusrcb 01, aluop 0.
  - MEMRD: adrsrc 1, resultsrc 00.
  - MEMWB: resultsrc 01, regw 1.
  - MEMWR: adrsrc 1. memw is 1 only on the final cycle.
  - EXECR: alusrcb 00, aluop 1.
  - EXECI: alusrcb 01, aluop 1.
  - ALUWB: resultsrc 00, regw 1.
  - BRANCH: alusrca 0, alusrcb 01, resultsrc 10, branch 1.
- Transitions:
  - FETCH -> DECODE on the final cycle.
  - DECODE -> EXECR if op = 00 and funct5 = 0.
  - DECODE -> EXECI if op = 00 and funct5 = 1.
  - DECODE -> MEMADR if op = 01.
  - DECODE -> BRANCH if op = 10.
  - DECODE -> FETCH if op = 11; illegal = 1 and instr_done = 1 in that DECODE cycle.
  - MEMADR -> MEMRD if funct0 = 1, else MEMWR.
  - MEMRD -> MEMWB on the final cycle.
  - MEMWB, ALUWB, BRANCH -> FETCH.
  - MEMWR -> FETCH on the final cycle.
  - EXECR, EXECI -> ALUWB.
- instr_done = 1 in: MEMWB, ALUWB, BRANCH, the final MEMWR cycle, and illegal DECODE.
- Inputs op, funct5 and funct0 are sampled only in DECODE and MEMADR; changes elsewhere are ignored.
- Latency with zero waits:
  - data-proc 4 cycles, load 5, store 4, branch 3, illegal 2.
  - IMEM_WAIT adds N cycles per instruction. DMEM_WAIT adds M cycles to each load and store.

Test Plan:
- Reset, zero waits: hold rst 3 cycles, release -> state 0. First cycle has irwrite = 1, nextpc = 1, alusrcb = 10, alusrca = 1; other strobes 0.
- op = 00, funct5 = 0, then op = 00, funct5 = 1, zero waits:
  - State sequences 0,1,6,8 then 0,1,7,8.
  - regw = 1 only in state 8; aluop = 1 in 6/7.
  - instr_done pulses at cycles 4 and 8.
- Load then store, DMEM_WAIT = 2:
  - Load visits 0,1,2,3,3,3,4: memw never 1, regw = 1 in 4.
  - Store visits 0,1,2,5,5,5: memw = 1 only in the third state-5 cycle.
- Branch op = 10, IMEM_WAIT = 3:
  - FETCH lasts 4 cycles with irwrite/nextpc only in the 4th; then 1, 9.
  - branch = 1 for exactly 1 cycle; instruction total 6 cycles.
- Illegal op = 11 -> states 0,1,0. illegal = 1 and instr_done = 1 in the DECODE cycle; regw = memw = branch = 0 throughout.
- rst asserted in state 5 with DMEM_WAIT = 2 on the first wait cycle -> memw stays 0. Next state is 0 and the counter restarts (memw never pulses for the aborted store).
